// File: rtl/sc_nadder_seq.sv
// Sequencer for one sc_nadder evaluation: LFSR-driven select streams, source enable, ones counting.
// Latency: start sampled at edge t -> RUN cycles t+1..t+len -> done pulse in cycle t+len+1.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) in RUN/DONE.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset, overrides everything including a run in progress
//   start      - evaluation request, sampled in IDLE only
//   len        - stream length in cycles, sampled with start (0 -> straight to DONE)
//   seed       - LFSR seed, sampled with start (0 is replaced by 16'hACE1)
//   sel        - select streams to sc_nadder.sel, sel[k] = lfsr[2k] during RUN, 0 otherwise
//   stream_en  - high in every RUN cycle so upstream sources present one bit per cycle
//   sc_out     - sc_nadder output, combinational in the same cycle as sel
//   busy       - high in RUN
//   done       - one-cycle pulse when the evaluation finishes
//   ones_count - ones seen on sc_out during the last evaluation, held until the next start

module sc_nadder_seq #(
    parameter int unsigned INPUT_STREAMS = 8,
    parameter int unsigned SELECT_WIDTH  = 3,
    parameter int unsigned LEN_WIDTH     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic [15:0]             seed,
    output logic [SELECT_WIDTH-1:0] sel,
    output logic                    stream_en,
    input  logic                    sc_out,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_WIDTH-1:0]    ones_count
);

    // Substitute seed whenever the requested seed is zero; a zero state would lock the LFSR.
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The select width must exactly address the adder inputs; a mismatch leaves
    // some adder inputs unreachable. The empty block only exists to flag that case
    // in an elaboration report.
    if (INPUT_STREAMS != (32'd1 << SELECT_WIDTH)) begin : g_param_mismatch
    end

    state_t                 state_q;
    state_t                 state_d;
    logic [15:0]            lfsr_q;
    logic [LEN_WIDTH-1:0]   remaining_q;

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting towards the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Even LFSR bits are used so neighbouring select lines are not simply
    // one-cycle-delayed copies of each other.
    function automatic logic [SELECT_WIDTH-1:0] sel_bits(input logic [15:0] v);
        logic [SELECT_WIDTH-1:0] s;
        s = '0;
        for (int k = 0; k < SELECT_WIDTH; k++) begin
            s[k] = v[2*k];
        end
        return s;
    endfunction

    //--------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------
    // FSM: next state
    //--------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // remaining still holds the count including the current cycle.
                if (remaining_q == LEN_WIDTH'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // FSM: outputs (decoded from registered state and LFSR, glitch-free
    // relative to the clock edge)
    //--------------------------------------------------------------------
    always_comb begin
        sel       = '0;
        stream_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_RUN: begin
                sel       = sel_bits(lfsr_q);
                stream_en = 1'b1;
                busy      = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    //--------------------------------------------------------------------
    // Datapath: LFSR, remaining-cycle counter, ones accumulator
    //--------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q      <= LFSR_DEFAULT;
            remaining_q <= '0;
            ones_count  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ones_count <= '0;
                        if (len != '0) begin
                            lfsr_q      <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
                            remaining_q <= len;
                        end
                    end
                end
                ST_RUN: begin
                    // ones_count <= len always holds, so the sum cannot wrap.
                    ones_count  <= ones_count + LEN_WIDTH'(sc_out);
                    lfsr_q      <= lfsr_step(lfsr_q);
                    remaining_q <= remaining_q - LEN_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
